// File: rtl/pattern_matcher_pkg.sv
// Shared constants, template-load FSM encoding and pipeline stage records
// for the 7x7 binary pattern matcher.
package pattern_matcher_pkg;
  localparam int WIN      = 7;
  localparam int WIN_BITS = 49;
  localparam int SCORE_W  = 6;
  localparam int STAGES   = 3;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_LOAD = 2'd1,
    TS_PEND = 2'd2
  } tmpl_state_t;

  // S1 -> S2: per-bit agreement plus the window's side information
  typedef struct packed {
    logic [WIN_BITS-1:0] agree;
    logic [9:0]          cx;
    logic [8:0]          cy;
    logic                rdy;
    logic                last;
  } s1_t;

  // S2 -> S3: 3-bit popcount per row group
  typedef struct packed {
    logic [WIN-1:0][2:0] grp;
    logic [9:0]          cx;
    logic [8:0]          cy;
    logic                rdy;
    logic                last;
  } s2_t;
endpackage

// File: rtl/pattern_matcher_popcount7.sv
// Combinational population count of a 7-bit group.
//  bits  in  7  group of agree bits
//  count out 3  number of set bits, 0..7
module pattern_matcher_popcount7 (
  input  logic [6:0] bits,
  output logic [2:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 7; i++) count = count + {2'b00, bits[i]};
  end
endmodule

// File: rtl/pattern_matcher.sv
// Final detection stage: binarises a 7x7 window against a threshold, scores
// agreement with a serially loaded template, flags matches and counts them
// per frame.
//  clk, reset (async, active-low)
//  window_valid, linear_mem1..7 : window rows 0..6, column c at [PIX_W*c +: PIX_W]
//  threshold, match_min         : binarisation level, minimum matching score
//  tmpl_start/tmpl_bit_valid/tmpl_bit : serial template load, first bit -> bit 48
//  tmpl_ready                   : a template has been committed since reset
//  match_valid/match/score/match_x/match_y : per in-frame window result
//  frame_done/match_count       : end-of-frame pulse and last frame's total
module pattern_matcher
  import pattern_matcher_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               window_valid,
  input  logic [7*PIX_W-1:0] linear_mem1,
  input  logic [7*PIX_W-1:0] linear_mem2,
  input  logic [7*PIX_W-1:0] linear_mem3,
  input  logic [7*PIX_W-1:0] linear_mem4,
  input  logic [7*PIX_W-1:0] linear_mem5,
  input  logic [7*PIX_W-1:0] linear_mem6,
  input  logic [7*PIX_W-1:0] linear_mem7,
  input  logic [PIX_W-1:0]   threshold,
  input  logic [5:0]         match_min,
  input  logic               tmpl_start,
  input  logic               tmpl_bit_valid,
  input  logic               tmpl_bit,
  output logic               tmpl_ready,
  output logic               match_valid,
  output logic               match,
  output logic [5:0]         score,
  output logic [9:0]         match_x,
  output logic [8:0]         match_y,
  output logic               frame_done,
  output logic [15:0]        match_count
);
  logic [WIN-1:0][7*PIX_W-1:0] rows;
  logic [WIN_BITS-1:0]         bin;
  logic [9:0]                  x_q;
  logic [8:0]                  y_q;
  logic                        frame_start, in_frame, last_win;

  assign rows = {linear_mem7, linear_mem6, linear_mem5, linear_mem4,
                 linear_mem3, linear_mem2, linear_mem1};

  for (genvar r = 0; r < WIN; r++) begin : g_row
    for (genvar c = 0; c < WIN; c++) begin : g_col
      assign bin[WIN*r+c] = rows[r][PIX_W*c +: PIX_W] >= threshold;
    end
  end

  // x/y give the position of the window presented this cycle
  assign frame_start = window_valid && (x_q == '0) && (y_q == '0);
  assign in_frame    = (x_q >= 10'd6) && (y_q >= 9'd6);
  assign last_win    = (x_q == 10'(IMG_W-1)) && (y_q == 9'(IMG_H-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (window_valid) begin
      if (x_q == 10'(IMG_W-1)) begin
        x_q <= '0;
        y_q <= (y_q == 9'(IMG_H-1)) ? '0 : y_q + 9'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  // ---- template load FSM ----
  tmpl_state_t         st_q, st_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [WIN_BITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic                ready_q, ready_d, commit;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    ready_d  = ready_q;
    commit   = 1'b0;
    if (tmpl_start) begin
      st_d  = TS_LOAD;
      cnt_d = '0;
    end else begin
      case (st_q)
        TS_LOAD: if (tmpl_bit_valid) begin
          shadow_d = {shadow_q[WIN_BITS-2:0], tmpl_bit};
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == 6'(WIN_BITS-1)) st_d = TS_PEND;
        end
        TS_PEND: if (frame_start) begin
          commit   = 1'b1;
          active_d = shadow_q;
          ready_d  = 1'b1;
          st_d     = TS_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= TS_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
    end
  end

  assign tmpl_ready = ready_q;

  // ---- pipeline ----
  logic [STAGES:1]       vld_pipe;
  s1_t                   s1_q;
  s2_t                   s2_q;
  logic [WIN-1:0][2:0]   grp;
  logic [SCORE_W-1:0]    score_c;
  logic                  hit;
  logic [15:0]           fcnt_q, tot;
  logic [WIN_BITS-1:0]   tmpl_use;

  // The committing window already sees the new template
  assign tmpl_use = commit ? shadow_q : active_q;

  for (genvar g = 0; g < WIN; g++) begin : g_pc
    pattern_matcher_popcount7 u_pc (.bits(s1_q.agree[WIN*g +: WIN]), .count(grp[g]));
  end

  always_comb begin
    score_c = '0;
    for (int g = 0; g < WIN; g++) score_c = score_c + {3'b000, s2_q.grp[g]};
  end

  assign hit = vld_pipe[2] && s2_q.rdy && (score_c >= match_min);
  assign tot = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + {15'd0, hit};
  assign match_valid = vld_pipe[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      score       <= '0;
      match       <= 1'b0;
      match_x     <= '0;
      match_y     <= '0;
      frame_done  <= 1'b0;
      match_count <= '0;
      fcnt_q      <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], window_valid && in_frame};
      s1_q.agree <= ~(bin ^ tmpl_use);
      s1_q.cx    <= x_q - 10'd3;
      s1_q.cy    <= y_q - 9'd3;
      s1_q.rdy   <= ready_d;
      s1_q.last  <= last_win;
      s2_q.grp   <= grp;
      s2_q.cx    <= s1_q.cx;
      s2_q.cy    <= s1_q.cy;
      s2_q.rdy   <= s1_q.rdy;
      s2_q.last  <= s1_q.last;
      score      <= score_c;
      match      <= hit;
      match_x    <= s2_q.cx;
      match_y    <= s2_q.cy;
      frame_done <= vld_pipe[2] && s2_q.last;
      if (vld_pipe[2] && s2_q.last) begin
        match_count <= tot;
        fcnt_q      <= '0;
      end else begin
        fcnt_q      <= tot;
      end
    end
  end
endmodule

// File: tb/tb_pattern_matcher.sv
module tb_pattern_matcher;
  localparam int W = 16, H = 8;
  localparam int BW = 300, BH = 245;

  logic clk = 0, reset = 0, wv = 0, wv_big = 0;
  logic [55:0] lm [7];
  logic [7:0] thr = 0;
  logic [5:0] mmin = 0;
  logic ts = 0, tbv = 0, tb = 0;
  logic tr, mv, mt, fd;
  logic [5:0] sc;
  logic [9:0] mx;
  logic [8:0] my;
  logic [15:0] mc;
  logic tr_b, mv_b, mt_b, fd_b;
  logic [5:0] sc_b;
  logic [9:0] mx_b;
  logic [8:0] my_b;
  logic [15:0] mc_b;

  always #5 clk = ~clk;

  pattern_matcher #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .window_valid(wv),
    .linear_mem1(lm[0]), .linear_mem2(lm[1]), .linear_mem3(lm[2]), .linear_mem4(lm[3]),
    .linear_mem5(lm[4]), .linear_mem6(lm[5]), .linear_mem7(lm[6]),
    .threshold(thr), .match_min(mmin), .tmpl_start(ts), .tmpl_bit_valid(tbv), .tmpl_bit(tb),
    .tmpl_ready(tr), .match_valid(mv), .match(mt), .score(sc), .match_x(mx), .match_y(my),
    .frame_done(fd), .match_count(mc));

  pattern_matcher #(.PIX_W(8), .IMG_W(BW), .IMG_H(BH)) dut_big (
    .clk(clk), .reset(reset), .window_valid(wv_big),
    .linear_mem1(lm[0]), .linear_mem2(lm[1]), .linear_mem3(lm[2]), .linear_mem4(lm[3]),
    .linear_mem5(lm[4]), .linear_mem6(lm[5]), .linear_mem7(lm[6]),
    .threshold(thr), .match_min(mmin), .tmpl_start(ts), .tmpl_bit_valid(tbv), .tmpl_bit(tb),
    .tmpl_ready(tr_b), .match_valid(mv_b), .match(mt_b), .score(sc_b), .match_x(mx_b), .match_y(my_b),
    .frame_done(fd_b), .match_count(mc_b));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- reference model (spec-level) ----
  typedef struct { int due; int score; bit match; int x; int y; bit last; int mc; } exp_t;
  exp_t q[$];
  int m_x = 0, m_y = 0, m_nbits = -1, m_fcnt = 0;
  bit [48:0] m_active = 0, m_shadow = 0;
  bit m_ready = 0, m_pend = 0;
  logic [15:0] m_mcount = 0;

  // stats from the scoreboard monitor
  int nvalid, nfd, first_x, first_y, last_x, last_y, last_score, fd_x, fd_y;
  bit last_match, fd_mv;
  int nfd_b = 0;
  logic [15:0] mc_b_at = 0;

  task automatic clear_stats();
    nvalid = 0; nfd = 0; first_x = -1; first_y = -1; last_x = -1; last_y = -1;
    last_score = -1; last_match = 0; fd_x = -1; fd_y = -1; fd_mv = 0;
  endtask

  task automatic model_reset();
    q.delete();
    m_x = 0; m_y = 0; m_nbits = -1; m_fcnt = 0; m_active = 0; m_shadow = 0;
    m_ready = 0; m_pend = 0; m_mcount = 0;
  endtask

  task automatic step(input bit v, input bit s, input bit bv, input bit b);
    bit commit, have, rd;
    bit [48:0] bin, tm;
    exp_t e;
    wv = v; ts = s; tbv = bv; tb = b;
    commit = v && m_pend && !s && m_x == 0 && m_y == 0;
    have = v && m_x >= 6 && m_y >= 6;
    if (have) begin
      for (int r = 0; r < 7; r++)
        for (int c = 0; c < 7; c++) bin[7*r+c] = lm[r][8*c +: 8] >= thr;
      tm = commit ? m_shadow : m_active;
      rd = commit || m_ready;
      e.score = 49 - $countones(bin ^ tm);
      e.match = rd && (e.score >= int'(mmin));
      e.x = m_x - 3; e.y = m_y - 3;
      e.last = (m_x == W-1) && (m_y == H-1);
      if (e.match && m_fcnt < 65535) m_fcnt++;
      e.mc = m_fcnt;
      if (e.last) m_fcnt = 0;
    end
    @(posedge clk); #1;
    if (s) begin m_nbits = 0; m_pend = 0; end
    else if (m_nbits >= 0 && bv) begin
      m_shadow = {m_shadow[47:0], b};
      m_nbits++;
      if (m_nbits == 49) begin m_nbits = -1; m_pend = 1; end
    end else if (commit) begin m_active = m_shadow; m_ready = 1; m_pend = 0; end
    if (v) begin
      m_x++;
      if (m_x == W) begin m_x = 0; m_y++; if (m_y == H) m_y = 0; end
    end
    if (have) begin e.due = cyc + 2; q.push_back(e); end
  endtask

  always @(negedge clk) begin
    bit ev;
    if (reset) begin
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      ev = q.size() > 0 && q[0].due == cyc;
      check("match_valid", mv, ev);
      check("frame_done", fd, ev && q[0].last);
      if (ev) begin
        check("score", sc, q[0].score);
        check("match", mt, q[0].match);
        check("match_x", mx, q[0].x);
        check("match_y", my, q[0].y);
        if (q[0].last) m_mcount = 16'(q[0].mc);
        void'(q.pop_front());
      end
      check("match_count", mc, m_mcount);
      check("tmpl_ready", tr, m_ready);
      if (mv) begin
        nvalid++;
        if (nvalid == 1) begin first_x = mx; first_y = my; end
        last_x = mx; last_y = my; last_score = sc; last_match = mt;
      end
      if (fd) begin nfd++; fd_x = mx; fd_y = my; fd_mv = mv; end
    end
  end

  always @(negedge clk) if (fd_b) begin nfd_b++; mc_b_at = mc_b; end

  task automatic set_win(input logic [7:0] p);
    for (int r = 0; r < 7; r++) lm[r] = {7{p}};
  endtask

  task automatic rand_win();
    for (int r = 0; r < 7; r++) lm[r] = 56'({$urandom(), $urandom()});
    thr = 8'($urandom_range(1, 255));
  endtask

  task automatic load_tmpl(input bit [48:0] t);
    step(0, 1, 0, 0);
    for (int i = 48; i >= 0; i--) step(0, 0, 1, t[i]);
  endtask

  task automatic stream_const(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  task automatic stream_rand(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      rand_win();
      step(gaps ? 1'($urandom_range(0, 1)) : 1'b1, 0, 0, 0);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
  endtask

  typedef struct { bit s; bit bv; bit b; } ti_t;

  initial begin
    bit [48:0] alt;
    ti_t tq[$];
    ti_t it;
    set_win(8'h00);
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tmpl_ready", tr, 0);   check("rst_match_valid", mv, 0);
    check("rst_match", mt, 0);        check("rst_score", sc, 0);
    check("rst_match_x", mx, 0);      check("rst_match_y", my, 0);
    check("rst_frame_done", fd, 0);   check("rst_match_count", mc, 0);
    check("rst_big_count", mc_b, 0);  check("rst_big_ready", tr_b, 0);
    @(posedge clk); #1 reset = 1;

    // 1 + 3: all-ones template on an all-255 window, one full frame
    thr = 8'd128; mmin = 6'd49; set_win(8'hFF);
    load_tmpl({49{1'b1}});
    check("ready_before_frame", tr, 0);
    step(1, 0, 0, 0);
    check("ready_at_frame_start", tr, 1);
    stream_const(W*H - 1);
    flush();
    check("t1_score", last_score, 49);
    check("t1_match", last_match, 1);
    check("t3_nvalid", nvalid, 20);
    check("t3_first_x", first_x, 3);  check("t3_first_y", first_y, 3);
    check("t3_last_x", last_x, 12);   check("t3_last_y", last_y, 4);
    check("t3_nfd", nfd, 1);
    check("t3_fd_x", fd_x, 12);       check("t3_fd_y", fd_y, 4);
    check("t3_fd_with_valid", fd_mv, 1);
    check("t3_count", mc, 20);

    // 2: alternating template (25 ones) against an all-zero window
    for (int k = 0; k < 49; k++) alt[k] = ~k[0];
    set_win(8'h00); mmin = 6'd25;
    load_tmpl(alt);
    clear_stats();
    stream_const(W*H); flush();
    check("t2_score", last_score, 24);
    check("t2_match_min25", last_match, 0);
    check("t2_count_min25", mc, 0);
    mmin = 6'd24;
    stream_const(W*H); flush();
    check("t2_match_min24", last_match, 1);
    check("t2_count_min24", mc, 20);

    // 4: mid-frame reload with an aborted partial load
    set_win(8'hFF); mmin = 6'd49;
    load_tmpl({49{1'b1}});
    stream_const(W*H); flush();
    tq.push_back('{1, 0, 0});
    for (int i = 0; i < 30; i++) tq.push_back('{0, 1, 1});
    tq.push_back('{1, 1, 1});
    for (int i = 0; i < 49; i++) tq.push_back('{0, 1, 0});
    clear_stats();
    for (int i = 0; i < W*H; i++) begin
      if (i >= 10 && tq.size() > 0) begin it = tq.pop_front(); step(1, it.s, it.bv, it.b); end
      else step(1, 0, 0, 0);
    end
    flush();
    check("t4_old_tmpl_count", mc, 20);
    check("t4_old_tmpl_score", last_score, 49);
    stream_const(W*H); flush();
    check("t4_new_tmpl_count", mc, 0);
    check("t4_new_tmpl_score", last_score, 0);

    // 5: random windows, back-to-back then with gaps, then reset mid-stream
    mmin = 6'($urandom_range(20, 30));
    load_tmpl({17'($urandom()), $urandom()});
    stream_rand(2*W*H, 0); flush();
    load_tmpl({17'($urandom()), $urandom()});
    stream_rand(300, 1); flush();
    for (int k = 0; k < 400 && !(m_x == 0 && m_y == 4); k++) begin rand_win(); step(1, 0, 0, 0); end
    stream_rand(50, 0);
    reset = 0;
    model_reset();
    @(negedge clk);
    check("r5_match_valid", mv, 0);   check("r5_match", mt, 0);
    check("r5_score", sc, 0);         check("r5_match_x", mx, 0);
    check("r5_match_y", my, 0);       check("r5_frame_done", fd, 0);
    check("r5_match_count", mc, 0);   check("r5_tmpl_ready", tr, 0);
    @(posedge clk); #1 reset = 1;
    clear_stats();
    stream_rand(W*H, 0); flush();
    check("r5_nvalid_after_reset", nvalid, 20);
    check("r5_first_x", first_x, 3);  check("r5_first_y", first_y, 3);
    check("r5_nfd", nfd, 1);

    // 6: saturation of the frame counter on a large image
    thr = 8'd128; mmin = 6'd49; set_win(8'hFF);
    load_tmpl({49{1'b1}});
    flush();
    wv_big = 1;
    repeat (BW*BH) @(posedge clk);
    #1 wv_big = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t6_big_ready", tr_b, 1);
    check("t6_big_nfd", nfd_b, 1);
    check("t6_big_count_at_fd", mc_b_at, 16'hFFFF);
    check("t6_big_count", mc_b, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
